// File: rtl/program_loader_if.sv
// Boot-loader bus bundle: byte-stream handshake in, instruction-memory write port
// and core-control status out.
interface program_loader_if #(
  parameter int CNT_W = 32
) ();
  logic             byte_valid_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o;
  logic             imem_we_o;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_wdata_o;
  logic             core_reset_o;
  logic             done_o;
  logic             error_o;
  logic [CNT_W-1:0] words_loaded_o;

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output imem_we_o,
    output imem_addr_o,
    output imem_wdata_o,
    output core_reset_o,
    output done_o,
    output error_o,
    output words_loaded_o
  );

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  imem_we_o,
    input  imem_addr_o,
    input  imem_wdata_o,
    input  core_reset_o,
    input  done_o,
    input  error_o,
    input  words_loaded_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed little-endian byte frame, writes 32-bit words
// to instruction memory, verifies a trailing 8-bit additive checksum and releases the core.
module program_loader #(
  parameter int IMEM_WORDS = 256,
  parameter int CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  program_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    csum_add = sum + data;
  endfunction

  state_e           state_q;
  logic [1:0]       byte_cnt_q;
  logic [23:0]      shift_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx_q;
  logic [7:0]       csum_q;
  logic             ready_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             core_reset_q;
  logic             done_q;
  logic             error_q;
  logic [CNT_W-1:0] words_loaded_q;

  logic             ready_s;
  logic             xfer_s;
  logic             last_byte_s;
  logic [31:0]      word_d;
  logic [7:0]       csum_d;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] len_d;

  // Ready is masked while reset is asserted so no byte is ever offered as accepted then.
  assign ready_s = ready_q & ~reset_i;
  assign xfer_s  = bus.byte_valid_i & ready_s;

  // Datapath next values shared by the header and payload states.
  always_comb begin
    word_d      = {bus.byte_data_i, shift_q};
    csum_d      = csum_add(csum_q, bus.byte_data_i);
    idx_d       = idx_q + CNT_ONE;
    len_d       = CNT_W'(word_d);
    last_byte_s = (byte_cnt_q == 2'd3);
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_LEN;
      byte_cnt_q     <= 2'd0;
      shift_q        <= 24'd0;
      len_q          <= '0;
      idx_q          <= '0;
      csum_q         <= 8'd0;
      ready_q        <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      core_reset_q   <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LEN: begin
          if (xfer_s) begin
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= word_d[31:8];
            if (last_byte_s) begin
              len_q <= len_d;
              if (len_d > MAX_WORDS) begin
                state_q <= S_ERR;
                ready_q <= 1'b0;
                error_q <= 1'b1;
              end else if (len_d == '0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= word_d[31:8];
            if (last_byte_s) begin
              we_q           <= 1'b1;
              wdata_q        <= word_d;
              addr_q         <= 32'({idx_q, 2'b00});
              idx_q          <= idx_d;
              words_loaded_q <= idx_d;
              if (idx_d == len_q) begin
                state_q <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (xfer_s) begin
            ready_q <= 1'b0;
            if (bus.byte_data_i == csum_q) begin
              state_q      <= S_RUN;
              core_reset_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q      <= S_ERR;
          ready_q      <= 1'b0;
          core_reset_q <= 1'b1;
          done_q       <= 1'b0;
          error_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready_o   = ready_s;
  assign bus.imem_we_o      = we_q;
  assign bus.imem_addr_o    = addr_q;
  assign bus.imem_wdata_o   = wdata_q;
  assign bus.core_reset_o   = core_reset_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are built from word lists, and expected
// writes/status are derived from the frame contents rather than from the loader's internals.
module tb_program_loader;

  localparam int IMEM_WORDS = 256;
  localparam int CNT_W      = 32;

  logic clk;
  logic reset;

  program_loader_if #(.CNT_W(CNT_W)) bus ();

  program_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wl_cnt = 0;
  logic [31:0] img[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_csum(input int unsigned n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 4; i++) s = s + 8'(n >> (8 * i));
    for (int w = 0; w < int'(n); w++)
      for (int k = 0; k < 4; k++) s = s + 8'(img[w] >> (8 * k));
    return s;
  endfunction

  // Every write strobe must match the next expected (address, data) pair in order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      wl_cnt = 0;
    end else begin
      if (bus.imem_we_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          wl_cnt++;
          chk("we_addr", bus.imem_addr_o, e[63:32]);
          chk("we_data", bus.imem_wdata_o, e[31:0]);
          chk("we_words_loaded", bus.words_loaded_o, 32'(wl_cnt));
        end
      end
      chk("core_reset_vs_done", {31'd0, bus.core_reset_o}, {31'd0, ~bus.done_o});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (!bus.byte_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.byte_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("rst_we", {31'd0, bus.imem_we_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'd0);
    chk("rst_wdata", bus.imem_wdata_o, 32'd0);
    chk("rst_core_reset", {31'd0, bus.core_reset_o}, 32'd1);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_error", {31'd0, bus.error_o}, 32'd0);
    chk("rst_words", bus.words_loaded_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.byte_ready_o}, 32'd1);
  endtask

  // stop_at < 0 sends the whole frame; otherwise stop after that many payload bytes.
  task automatic send_frame(input int unsigned n, input bit bad_csum, input int gap, input int stop_at);
    logic [7:0] sum;
    int sent;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(n >> (8 * i)));
      idle(gap);
    end
    if (n > IMEM_WORDS) begin
      chk("ovf_error", {31'd0, bus.error_o}, 32'd1);
      chk("ovf_core_reset", {31'd0, bus.core_reset_o}, 32'd1);
      chk("ovf_ready", {31'd0, bus.byte_ready_o}, 32'd0);
      chk("ovf_words", bus.words_loaded_o, 32'd0);
      return;
    end
    sum  = model_csum(n);
    sent = 0;
    for (int w = 0; w < int'(n); w++) begin
      for (int k = 0; k < 4; k++) begin
        if (sent == stop_at) return;
        if (k == 3) exp_q.push_back({32'(w * 4), img[w]});
        send_byte(8'(img[w] >> (8 * k)));
        idle(gap);
        sent++;
      end
    end
    chk("pre_csum_done", {31'd0, bus.done_o}, 32'd0);
    chk("pre_csum_core_reset", {31'd0, bus.core_reset_o}, 32'd1);
    send_byte(bad_csum ? sum + 8'd1 : sum);
    chk("end_done", {31'd0, bus.done_o}, {31'd0, ~bad_csum});
    chk("end_error", {31'd0, bus.error_o}, {31'd0, bad_csum});
    chk("end_core_reset", {31'd0, bus.core_reset_o}, {31'd0, bad_csum});
    chk("end_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("end_words", bus.words_loaded_o, 32'(n));
    chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'd0;
    do_reset();

    img = '{32'h00000013, 32'h00500093};
    chk("model_csum_n2", {24'd0, model_csum(2)}, 32'h000000F8);
    send_frame(2, 1'b0, 0, -1);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'hAA;
    idle(3);
    bus.byte_valid_i = 1'b0;
    chk("run_hold_done", {31'd0, bus.done_o}, 32'd1);
    chk("run_hold_words", bus.words_loaded_o, 32'd2);

    do_reset();
    send_frame(2, 1'b1, 0, -1);

    do_reset();
    img = '{};
    chk("model_csum_n0", {24'd0, model_csum(0)}, 32'h00000000);
    send_frame(0, 1'b0, 0, -1);

    do_reset();
    send_frame(IMEM_WORDS + 1, 1'b0, 0, -1);
    idle(3);
    chk("ovf_stays_error", {31'd0, bus.error_o}, 32'd1);

    do_reset();
    img = '{32'hDEADBEEF};
    chk("model_csum_deadbeef", {24'd0, model_csum(1)}, 32'h00000039);
    send_frame(1, 1'b0, 2, -1);

    do_reset();
    img = '{32'h11223344, 32'h55667788};
    send_frame(2, 1'b0, 0, 6);
    idle(2);
    chk("abort_words_before_rst", bus.words_loaded_o, 32'd1);
    do_reset();
    chk("abort_no_pending", 32'(exp_q.size()), 32'd0);
    img = '{32'hCAFEF00D};
    send_frame(1, 1'b0, 0, -1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the core's instruction memory.
- Receives a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, writes them into instruction memory, and verifies a trailing checksum.
- Holds the processor core in reset until the image is loaded and verified.
- On checksum mismatch or an oversized image, the core stays in reset permanently until the next reset.

Parameters:
- IMEM_WORDS, 256, instruction memory capacity in 32-bit words; maximum accepted image length.
- CNT_W, 32, width of the header length field and of the word counters.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- byte_valid_i  input  1  upstream presents a byte.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- imem_we_o  output  1  instruction memory write strobe, one cycle per word.
- imem_addr_o  output  32  byte address of the word being written (word_index*4).
- imem_wdata_o  output  32  assembled instruction word.
- core_reset_o  output  1  reset to the processor core; high until load verified.
- done_o  output  1  load completed and checksum matched.
- error_o  output  1  load failed (length overflow or checksum mismatch).
- words_loaded_o  output  CNT_W  count of words written so far.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - reset_i is synchronous and active-high.
- Reset values:
  - State = S_LEN.
  - byte_ready_o=0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - imem_we_o=0, imem_addr_o=0, imem_wdata_o=0.
  - core_reset_o=1, done_o=0, error_o=0, words_loaded_o=0.
  - Byte counter=0, checksum=0.
- Handshake:
  - A byte transfers on a rising edge where byte_valid_i && byte_ready_o.
  - byte_ready_o=1 in S_LEN, S_DATA and S_CSUM; 0 in S_RUN and S_ERR.
  - No back-pressure inside the loading states: one byte per cycle sustained.
- Frame format:
  - 4-byte word count N, little-endian.
  - N*4 payload bytes; each word is little-endian, so the first byte maps to [7:0].
  - 1 checksum byte, equal to the 8-bit sum (mod 256) of all preceding length and payload bytes.
- States:
  - S_LEN:
    - Shift in 4 bytes and add each to the checksum.
    - After the 4th byte: if N > IMEM_WORDS -> S_ERR.
    - Else if N == 0 -> S_CSUM.
    - Else -> S_DATA.
  - S_DATA:
    - Assemble bytes and add each to the checksum.
    - On the 4th byte of a word, the next cycle drives imem_we_o=1 for exactly one cycle with imem_wdata_o = the assembled word and imem_addr_o = index*4.
    - words_loaded_o increments in that same cycle.
    - Byte acceptance continues uninterrupted during the write cycle.
    - After the 4th byte of word N-1 -> S_CSUM.
  - S_CSUM:
    - On the accepted byte: if it equals the running sum -> S_RUN, else -> S_ERR.
    - The final word's write strobe may coincide with the S_CSUM cycle.
  - S_RUN:
    - core_reset_o=0 and done_o=1 from the cycle after the checksum byte is accepted.
    - Terminal state; input bytes are ignored.
  - S_ERR:
    - error_o=1, core_reset_o stays 1.
    - Terminal state.
- Arithmetic and widths:
  - Checksum is an 8-bit wrapping adder.
  - Word index is compared against N at CNT_W bits.
  - imem_addr_o is the index shifted left by 2, zero-extended to 32 bits.
- Idle bytes: byte_valid_i low for any number of cycles causes no state change and no partial-word corruption; byte assembly resumes where it stopped.
- Reset mid-load:
  - Aborts the load and returns to the reset values; any in-flight write strobe is suppressed.
  - Memory contents already written are not cleared.
  - A fresh frame is required.
- Reset in S_RUN or S_ERR: the core is re-held in reset and the loader restarts in S_LEN.

Test Plan:
- N=2, words 0x00000013, 0x00500093, correct checksum (0x02+0x13+0x93+0x50 = 0xF8), back-to-back bytes -> two write strobes at addr 0x0 and 0x4 with the exact data; done_o=1, core_reset_o=0 one cycle after the checksum byte; words_loaded_o=2.
- Same frame with the checksum byte 0xF9 -> both words written; error_o=1, core_reset_o stays 1, byte_ready_o=0.
- N=0, checksum 0x00 -> no write strobes; done_o=1 after 5 accepted bytes.
- N=IMEM_WORDS+1 (257) -> S_ERR immediately after the 4th header byte; no imem_we_o pulses; error_o=1.
- N=1 with byte_valid_i toggled 1,0,0,1,… between every byte -> identical write data 0xDEADBEEF at addr 0; no spurious strobes.
- reset_i asserted after 2 payload bytes of word 1, then a clean N=1 frame -> no strobe for the aborted word; the new word is written at addr 0; done_o=1.
